timer: RTL and testbench
========================

# timer

Memory-mapped 32-bit timer peripheral on the CPU data bus, alongside RAM, the UART and the 1-bit output register. It counts prescaled clock ticks, compares against a programmable value, latches a match flag and drives a level interrupt. The top level decodes it at byte addresses 0x10010–0x1001C (`sel = addr[29:2] == 28'h1001`). Read data returns one cycle after `re`, matching RAM read latency, so it joins the existing `rdata` mux.

## Interface
- `RESET_COMPARE`, default 32'hFFFF_FFFF: reset value of COMPARE.
- `clk`  in  1  system clock; all state updates on rising edge.
- `reset`  in  1  synchronous, active-high reset.
- `sel`  in  1  block selected by top-level address decode.
- `addr`  in  2  word offset within the block: 0 COUNT, 1 COMPARE, 2 CTRL, 3 STATUS.
- `re`  in  1  read strobe, qualified by `sel`.
- `we`  in  4  byte write enables, qualified by `sel`; `we[i]` covers `wdata[8i+7:8i]`.
- `wdata`  in  32  write data.
- `rdata`  out  32  registered read data.
- `irq`  out  1  level interrupt: `STATUS.match & CTRL.ie`.

## Operation
- COUNT[31:0]: read/write; free-running up-counter.
- COMPARE[31:0]: read/write.
- CTRL: bit0 `en`, bit1 `reload` (auto-reload), bit2 `ie`, bits[15:8] `pre` (prescale). Other bits read 0 and ignore writes.
- STATUS: bit0 `match`; writing 1 with `we[0]` clears it, writing 0 has no effect. Bits[31:1] read 0.
- Prescaler, 8 bits: when `en=0`, held at 0. When `en=1`, it increments each cycle and asserts `tick` when it equals `pre`, then wraps to 0. With `pre=0`, `tick` fires every cycle.
- On `tick`:
  - If COUNT == COMPARE: set `match`. COUNT becomes 0 if `reload=1`, else COUNT+1.
  - Otherwise COUNT becomes COUNT+1.
  - 32-bit wrap: 0xFFFF_FFFF+1 = 0, with no flag.
- Byte writes update only the enabled bytes of COUNT, COMPARE and CTRL.
- Writes while `sel=0` are ignored. `re` and `we` in the same cycle are legal.

## Timing
- Reset: COUNT=0, COMPARE=`RESET_COMPARE`, CTRL=0, STATUS=0, prescaler=0, `rdata`=0, `irq`=0.
- Read latency: `rdata` is valid on the cycle after `sel & re`.
  - It returns the register value sampled before any same-cycle write or tick.
  - `rdata` is 0 in any cycle not following a qualified read, so OR-combining is safe.
- Write latency: the register holds the new value on the next cycle.
- `irq` is registered-consistent: it follows `match`/`ie` one cycle after they change (combinational from the flops).
- Simultaneous COUNT write and `tick`: the CPU write wins for the written bytes. Unwritten bytes take the tick-updated value. The compare uses the pre-write COUNT.
- Simultaneous STATUS clear and match set: set wins, so `match` stays 1.
- Changing CTRL `en` 1→0: the prescaler resets to 0 on the next cycle and COUNT freezes. A pending tick in the same cycle as the write still applies.
- Writing `pre` mid-count: takes effect immediately. If the prescaler exceeds the new `pre`, it runs to 255, wraps to 0, then matches normally.
- `reset` asserted mid-operation overrides every write and tick in that cycle.

## Structure
- Package `timer_pkg`:
  - Register offsets `TIMER_COUNT`, `TIMER_COMPARE`, `TIMER_CTRL`, `TIMER_STATUS`.
  - CTRL bit positions `CTRL_EN`, `CTRL_RELOAD`, `CTRL_IE`, plus field `CTRL_PRE_LSB`/`MSB`.
  - Base word address `TIMER_BASE = 28'h1001` for top-level decode.
- Sub-module `timer_prescaler`: inputs `clk`, `reset`, `en`, `pre[7:0]`; output `tick`. Holds the 8-bit counter.
- Byte-merge of writes is a shared function in the package.

## Test plan
- Reset release, then read each offset → COUNT 0, COMPARE 0xFFFF_FFFF, CTRL 0, STATUS 0; `rdata` returns 0 on idle cycles; `irq` 0.
- CTRL=0x0000_0301 (`pre`=3, `en`) and run 40 cycles → COUNT increments once every 4 cycles; reads show 10 ±1 per exact tick phase, and the bench checks the exact value.
- COMPARE=5, CTRL=0x7 (`en`, `reload`, `ie`, `pre`=0) → COUNT sequence 0..5, 0..5; `match`=1 and `irq`=1 the cycle after the first COUNT==5 tick. Writing STATUS=1 clears both; they re-set six cycles later.
- COUNT=0xFFFF_FFFE, COMPARE=3, `en`, no reload → COUNT goes to 0xFFFF_FFFF, 0, 1, 2, 3, 4; `match` sets only at COUNT==3.
- Byte write `we`=4'b0010 to COMPARE with `wdata`=0xAABBCCDD while COMPARE=0x11223344 → COMPARE reads 0x1122CC44.
- STATUS clear in the same cycle as a match tick → `match` remains 1. COUNT write in the same cycle as a tick → the written value is kept. `reset` pulse mid-count → all registers return to reset values.

Source files
------------

// File: rtl/timer_pkg.sv
// timer_pkg: shared definitions for the memory-mapped timer peripheral.
//   - register word offsets within the block
//   - CTRL bit positions / prescale field bounds and writable-bit mask
//   - base word address for the top-level address decode
//   - byte_merge(): applies byte enables of a bus write to a 32-bit register
package timer_pkg;

  localparam logic [1:0] TIMER_COUNT   = 2'd0;
  localparam logic [1:0] TIMER_COMPARE = 2'd1;
  localparam logic [1:0] TIMER_CTRL    = 2'd2;
  localparam logic [1:0] TIMER_STATUS  = 2'd3;

  localparam int CTRL_EN      = 0;
  localparam int CTRL_RELOAD  = 1;
  localparam int CTRL_IE      = 2;
  localparam int CTRL_PRE_LSB = 8;
  localparam int CTRL_PRE_MSB = 15;

  // Only en/reload/ie and the prescale byte exist; everything else reads 0.
  localparam logic [31:0] CTRL_MASK = 32'h0000_FF07;

  // Word address of the block as seen by the top-level decode (addr[29:2]).
  localparam logic [27:0] TIMER_BASE = 28'h1001;

  // Replace each byte of old_val whose enable is set with the same byte of new_val.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] r;
    r = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) r[8*i +: 8] = new_val[8*i +: 8];
    end
    return r;
  endfunction

endpackage

// File: rtl/timer_prescaler.sv
// timer_prescaler: 8-bit clock prescaler for the timer.
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   en    in  counting enable; counter is held at 0 while low
//   pre   in  terminal value; tick fires when the counter equals it
//   tick  out one-cycle pulse, every (pre+1) cycles while enabled
module timer_prescaler (
  input  logic       clk,
  input  logic       reset,
  input  logic       en,
  input  logic [7:0] pre,
  output logic       tick
);

  logic [7:0] cnt_q, cnt_d;

  // Equality (not >=) is deliberate: if pre is lowered below the current
  // count, the counter runs on to 255 and wraps before matching again.
  assign tick = en && (cnt_q == pre);

  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = 8'd0;
    end else if (tick) begin
      cnt_d = 8'd0;
    end else begin
      cnt_d = cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= 8'd0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule

// File: rtl/timer.sv
// timer: memory-mapped 32-bit timer with compare match and level interrupt.
//   clk   in  system clock
//   reset in  synchronous active-high reset
//   sel   in  block select from top-level decode
//   addr  in  word offset: 0 COUNT, 1 COMPARE, 2 CTRL, 3 STATUS
//   re    in  read strobe (qualified by sel)
//   we    in  byte write enables (qualified by sel)
//   wdata in  write data
//   rdata out registered read data, 0 when no read was issued last cycle
//   irq   out STATUS.match & CTRL.ie
module timer
  import timer_pkg::*;
#(
  parameter logic [31:0] RESET_COMPARE = 32'hFFFF_FFFF
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        sel,
  input  logic [1:0]  addr,
  input  logic        re,
  input  logic [3:0]  we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  output logic        irq
);

  logic [31:0] count_q,   count_d;
  logic [31:0] compare_q, compare_d;
  logic [31:0] ctrl_q,    ctrl_d;
  logic        match_q,   match_d;
  logic [31:0] rdata_q,   rdata_d;

  logic        tick;
  logic        wr_any;
  logic        wr_count, wr_compare, wr_ctrl;
  logic        clr_match;
  logic        hit;
  logic [31:0] count_ticked;

  timer_prescaler u_prescaler (
    .clk   (clk),
    .reset (reset),
    .en    (ctrl_q[CTRL_EN]),
    .pre   (ctrl_q[CTRL_PRE_MSB:CTRL_PRE_LSB]),
    .tick  (tick)
  );

  assign wr_any     = sel && (we != 4'b0000);
  assign wr_count   = wr_any && (addr == TIMER_COUNT);
  assign wr_compare = wr_any && (addr == TIMER_COMPARE);
  assign wr_ctrl    = wr_any && (addr == TIMER_CTRL);
  assign clr_match  = sel && (addr == TIMER_STATUS) && we[0] && wdata[0];

  // Compare always uses the pre-write COUNT so a same-cycle CPU write
  // cannot create or suppress a match.
  assign hit = tick && (count_q == compare_q);

  always_comb begin
    count_ticked = count_q;
    if (tick) begin
      if (hit && ctrl_q[CTRL_RELOAD]) begin
        count_ticked = 32'd0;
      end else begin
        count_ticked = count_q + 32'd1;
      end
    end
  end

  always_comb begin
    // CPU write wins for the written bytes; the rest follow the tick update.
    count_d   = wr_count   ? byte_merge(count_ticked, wdata, we) : count_ticked;
    compare_d = wr_compare ? byte_merge(compare_q, wdata, we) : compare_q;
    ctrl_d    = wr_ctrl    ? (byte_merge(ctrl_q, wdata, we) & CTRL_MASK) : ctrl_q;
    // Set has priority over a same-cycle clear.
    match_d   = hit || (match_q && !clr_match);

    rdata_d = 32'd0;
    if (sel && re) begin
      case (addr)
        TIMER_COUNT:   rdata_d = count_q;
        TIMER_COMPARE: rdata_d = compare_q;
        TIMER_CTRL:    rdata_d = ctrl_q;
        default:       rdata_d = {31'd0, match_q};
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q   <= 32'd0;
      compare_q <= RESET_COMPARE;
      ctrl_q    <= 32'd0;
      match_q   <= 1'b0;
      rdata_q   <= 32'd0;
    end else begin
      count_q   <= count_d;
      compare_q <= compare_d;
      ctrl_q    <= ctrl_d;
      match_q   <= match_d;
      rdata_q   <= rdata_d;
    end
  end

  assign rdata = rdata_q;
  assign irq   = match_q && ctrl_q[CTRL_IE];

endmodule

// File: tb/tb_timer.sv
module tb_timer;

  logic        clk = 1'b0;
  logic        reset;
  logic        sel;
  logic [1:0]  addr;
  logic        re;
  logic [3:0]  we;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic        irq;

  int total = 0;
  int bad   = 0;

  logic [31:0] exp_q[$];
  string       tag_q[$];
  logic        rd_v   = 1'b0;
  logic        mon_on = 1'b0;

  localparam logic [1:0] A_COUNT = 2'd0, A_CMP = 2'd1, A_CTRL = 2'd2, A_STAT = 2'd3;

  timer #(.RESET_COMPARE(32'hFFFF_FFFF)) dut (
    .clk   (clk),
    .reset (reset),
    .sel   (sel),
    .addr  (addr),
    .re    (re),
    .we    (we),
    .wdata (wdata),
    .rdata (rdata),
    .irq   (irq)
  );

  always #5 clk = ~clk;

  // A read was issued at this edge; its data is expected until the next edge.
  always @(posedge clk) rd_v <= sel & re;

  // Monitor: pops expected read data whenever the DUT presents a read response,
  // otherwise requires the idle value 0.
  always @(negedge clk) begin
    if (mon_on) begin
      if (rd_v) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL unexpected_read: got %h required no read", rdata);
        end else begin
          logic [31:0] e;
          string t;
          e = exp_q.pop_front();
          t = tag_q.pop_front();
          if (rdata !== e) begin
            bad++;
            $display("FAIL %s: got %h required %h", t, rdata, e);
          end else begin
            $display("read %s: %h", t, rdata);
          end
        end
      end else begin
        total++;
        if (rdata !== 32'd0) begin
          bad++;
          $display("FAIL idle_rdata: got %h required 00000000", rdata);
        end
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus_write(input logic [1:0] a, input logic [31:0] d, input logic [3:0] w);
    sel = 1'b1; addr = a; wdata = d; we = w; re = 1'b0;
    @(posedge clk); #1;
    sel = 1'b0; we = 4'b0000;
    $display("write addr=%0d data=%h we=%b", a, d, w);
  endtask

  task automatic bus_read(input logic [1:0] a, input logic [31:0] e, input string t);
    exp_q.push_back(e);
    tag_q.push_back(t);
    sel = 1'b1; addr = a; re = 1'b1; we = 4'b0000;
    @(posedge clk); #1;
    sel = 1'b0; re = 1'b0;
  endtask

  task automatic check(input string t, input logic [31:0] got, input logic [31:0] e);
    total++;
    if (got !== e) begin
      bad++;
      $display("FAIL %s: got %h required %h", t, got, e);
    end else begin
      $display("check %s: %h", t, got);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    idle(2);
    reset = 1'b0;
  endtask

  initial begin
    logic [31:0] seq1 [12];
    logic [31:0] seq2 [5];
    seq1 = '{32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5,
             32'd0, 32'd1, 32'd2, 32'd3, 32'd4, 32'd5};
    seq2 = '{32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'd0, 32'd1, 32'd2};

    reset = 1'b1; sel = 1'b0; addr = 2'd0; re = 1'b0; we = 4'b0000; wdata = 32'd0;
    repeat (3) @(posedge clk);
    #1;
    reset  = 1'b0;
    mon_on = 1'b1;

    // Reset values
    check("reset_irq", {31'd0, irq}, 32'd0);
    bus_read(A_COUNT, 32'd0, "reset_count");
    bus_read(A_CMP, 32'hFFFF_FFFF, "reset_compare");
    bus_read(A_CTRL, 32'd0, "reset_ctrl");
    bus_read(A_STAT, 32'd0, "reset_status");
    idle(2);

    // Prescale 3: one COUNT increment every 4 cycles
    bus_write(A_CTRL, 32'h0000_0301, 4'hF);
    idle(40);
    bus_read(A_COUNT, 32'd10, "pre3_count_40");
    bus_write(A_CTRL, 32'hFFFF_0300, 4'hF);   // en off, unused bits dropped
    bus_read(A_COUNT, 32'd10, "pre3_after_disable");
    idle(8);
    bus_read(A_COUNT, 32'd10, "pre3_frozen");
    bus_read(A_CTRL, 32'h0000_0300, "ctrl_mask");

    // Compare 5 with reload and ie, pre 0
    do_reset();
    bus_write(A_CMP, 32'd5, 4'hF);
    bus_write(A_CTRL, 32'h0000_0007, 4'hF);
    for (int i = 0; i < 12; i++) bus_read(A_COUNT, seq1[i], $sformatf("reload_seq%0d", i));
    check("reload_irq_set", {31'd0, irq}, 32'd1);
    bus_read(A_STAT, 32'd1, "reload_match");
    bus_write(A_STAT, 32'd1, 4'b0001);
    check("clear_irq", {31'd0, irq}, 32'd0);
    bus_read(A_STAT, 32'd0, "cleared_status");
    idle(2);
    check("irq_before_reset", {31'd0, irq}, 32'd0);
    idle(1);
    check("irq_reset6", {31'd1 & 31'd0, irq}, 32'd1);
    idle(5);
    bus_write(A_STAT, 32'd1, 4'b0001);        // same cycle as a match tick
    bus_read(A_STAT, 32'd1, "set_beats_clear");
    check("irq_set_beats_clear", {31'd0, irq}, 32'd1);

    // 32-bit wrap, no reload, compare 3
    do_reset();
    bus_write(A_COUNT, 32'hFFFF_FFFE, 4'hF);
    bus_write(A_CMP, 32'd3, 4'hF);
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    for (int i = 0; i < 5; i++) bus_read(A_COUNT, seq2[i], $sformatf("wrap_seq%0d", i));
    bus_read(A_STAT, 32'd0, "wrap_no_flag");
    bus_read(A_STAT, 32'd1, "wrap_match3");
    bus_read(A_COUNT, 32'd5, "wrap_no_reload");

    // Byte writes
    bus_write(A_CMP, 32'h1122_3344, 4'hF);
    bus_write(A_CMP, 32'hAABB_CCDD, 4'b0010);
    bus_read(A_CMP, 32'h1122_CC44, "byte_compare");
    bus_write(A_CTRL, 32'hFFFF_FFFF, 4'b0001);
    bus_read(A_CTRL, 32'h0000_0007, "byte_ctrl");

    // COUNT write colliding with a tick
    do_reset();
    bus_write(A_CTRL, 32'h0000_0001, 4'hF);
    bus_write(A_COUNT, 32'h0000_0100, 4'hF);
    bus_read(A_COUNT, 32'h0000_0100, "write_wins");
    bus_read(A_COUNT, 32'h0000_0101, "after_write");
    bus_write(A_COUNT, 32'h0000_0055, 4'b0001);
    bus_read(A_COUNT, 32'h0000_0155, "partial_write_tick");

    // Reset mid-count overrides a same-cycle write
    bus_write(A_CMP, 32'd7, 4'hF);
    reset = 1'b1;
    bus_write(A_COUNT, 32'h0000_1234, 4'hF);
    idle(1);
    reset = 1'b0;
    check("midreset_irq", {31'd0, irq}, 32'd0);
    bus_read(A_COUNT, 32'd0, "midreset_count");
    bus_read(A_CMP, 32'hFFFF_FFFF, "midreset_compare");
    bus_read(A_CTRL, 32'd0, "midreset_ctrl");
    bus_read(A_STAT, 32'd0, "midreset_status");

    idle(3);
    check("scoreboard_drained", exp_q.size(), 32'd0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
